// File: rtl/io_requester_pt.sv
// Virtually addressed RD/WR requester: pagetable translation, credit-based queues, sticky fault reporting.
// Optional performance counters are compiled in when IO_REQ_PERF_CNT_EN is defined.

module io_req_chan #(
  parameter int PT_LATENCY      = 3,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int VADDR_W         = 58,
  parameter int PADDR_W         = 32,
  parameter int PASS_W          = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [VADDR_W-1:0] req_vaddr,
  input  logic [PASS_W-1:0]  req_pass,
  output logic               pt_re,
  output logic [VADDR_W-1:0] virt_addr,
  input  logic [PADDR_W-1:0] phy_addr,
  input  logic               phy_valid,
  output logic               xl_valid,
  input  logic               xl_ready,
  output logic [PADDR_W-1:0] xl_paddr,
  output logic [PASS_W-1:0]  xl_pass,
  output logic               fault_evt,
  output logic [VADDR_W-1:0] fault_vaddr
);
  localparam int D     = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int ENT_W = PASS_W + PADDR_W;
  localparam logic [CW:0] DEPTH = (CW+1)'(D);

  logic [PT_LATENCY:1]        vld_p;
  logic [VADDR_W-1:0]         vaddr_p [1:PT_LATENCY];
  logic [PASS_W-1:0]          pass_p  [1:PT_LATENCY];
  logic                       res_vld;
  logic [PADDR_W-1:0]         res_paddr;
  logic [PASS_W-1:0]          res_pass;
  logic [ENT_W-1:0]           mem [D];
  logic [FIFO_DEPTH_BITS-1:0] wptr, rptr;
  logic [CW-1:0]              count, inflight;
  logic [CW:0]                used;
  logic                       accept, sample_hit, sample_miss, leave, pop;

  // Credit covers everything accepted but not yet queued, so the queue never overflows.
  assign used        = {1'b0, count} + {1'b0, inflight};
  assign req_ready   = rst_n & (used < DEPTH);
  assign accept      = req_valid & req_ready;
  assign sample_hit  = vld_p[PT_LATENCY] & phy_valid;
  assign sample_miss = vld_p[PT_LATENCY] & ~phy_valid;
  assign leave       = sample_miss | res_vld;
  assign pop         = (~xl_valid | xl_ready) & (count != '0);

  assign pt_re       = vld_p[1];
  assign virt_addr   = vaddr_p[1];
  assign fault_evt   = sample_miss;
  assign fault_vaddr = vaddr_p[PT_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 1; k <= PT_LATENCY; k++) vaddr_p[k] <= '0;
      inflight <= '0;
      res_vld  <= 1'b0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      xl_valid <= 1'b0;
      xl_paddr <= '0;
      xl_pass  <= '0;
    end else begin
      // p1: lookup strobe; p2..pN: wait for the pagetable result
      vld_p[1] <= accept;
      if (accept) vaddr_p[1] <= req_vaddr;
      for (int k = 2; k <= PT_LATENCY; k++) begin
        vld_p[k]   <= vld_p[k-1];
        vaddr_p[k] <= vaddr_p[k-1];
      end
      // result register -> queue
      res_vld <= sample_hit;
      case ({accept, leave})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (res_vld) wptr <= wptr + FIFO_DEPTH_BITS'(1);
      case ({res_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // queue -> output register
      if (pop) begin
        rptr                <= rptr + FIFO_DEPTH_BITS'(1);
        {xl_pass, xl_paddr} <= mem[rptr];
        xl_valid            <= 1'b1;
      end else if (xl_ready) begin
        xl_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pass_p[1] <= req_pass;
    for (int k = 2; k <= PT_LATENCY; k++) pass_p[k] <= pass_p[k-1];
    res_paddr <= phy_addr;
    res_pass  <= pass_p[PT_LATENCY];
    if (res_vld) mem[wptr] <= {res_pass, res_paddr};
  end
endmodule

module io_requester_pt #(
  parameter int PT_LATENCY      = 3,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int VADDR_W         = 58,
  parameter int PADDR_W         = 32,
  parameter int OFS_W           = 13,
  parameter int WR_META_W       = 4,
  parameter int DATA_W          = 512
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   cor_tx_rd_ready,
  input  logic                                   cor_tx_rd_valid,
  input  logic [VADDR_W+OFS_W-1:0]               cor_tx_rd_hdr,
  output logic                                   cor_tx_wr_ready,
  input  logic                                   cor_tx_wr_valid,
  input  logic [WR_META_W+VADDR_W+OFS_W-1:0]     cor_tx_wr_hdr,
  input  logic [DATA_W-1:0]                      cor_tx_data,
  input  logic                                   rq_tx_rd_ready,
  output logic                                   rq_tx_rd_valid,
  output logic [PADDR_W+OFS_W-1:0]               rq_tx_rd_hdr,
  input  logic                                   rq_tx_wr_ready,
  output logic                                   rq_tx_wr_valid,
  output logic [WR_META_W+PADDR_W+OFS_W-1:0]     rq_tx_wr_hdr,
  output logic [DATA_W-1:0]                      rq_tx_data,
  output logic                                   pt_re_rd,
  output logic                                   pt_re_wr,
  output logic [VADDR_W-1:0]                     afu_virt_rd_addr,
  output logic [VADDR_W-1:0]                     afu_virt_wr_addr,
  input  logic [PADDR_W-1:0]                     afu_phy_rd_addr,
  input  logic [PADDR_W-1:0]                     afu_phy_wr_addr,
  input  logic                                   afu_phy_rd_addr_valid,
  input  logic                                   afu_phy_wr_addr_valid,
  input  logic                                   fault_clr,
  output logic                                   rd_fault,
  output logic                                   wr_fault,
  output logic [VADDR_W-1:0]                     fault_vaddr,
  output logic [15:0]                            fault_cnt
`ifdef IO_REQ_PERF_CNT_EN
  ,
  output logic [31:0]                            rd_req_cnt,
  output logic [31:0]                            wr_req_cnt,
  output logic [31:0]                            rd_stall_cnt,
  output logic [31:0]                            wr_stall_cnt
`endif
);
  localparam int WP_W = WR_META_W + DATA_W + OFS_W;

  logic [OFS_W-1:0]   rd_pass;
  logic [PADDR_W-1:0] rd_paddr, wr_paddr;
  logic [WP_W-1:0]    wr_pass_in, wr_pass;
  logic               rd_evt, wr_evt;
  logic [VADDR_W-1:0] rd_fvaddr, wr_fvaddr;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Write payload rides the channel as {wmeta, data, meta} and is split back out on exit.
  assign wr_pass_in = {cor_tx_wr_hdr[WR_META_W+VADDR_W+OFS_W-1 -: WR_META_W], cor_tx_data,
                       cor_tx_wr_hdr[OFS_W-1:0]};

  io_req_chan #(.PT_LATENCY(PT_LATENCY), .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS), .VADDR_W(VADDR_W),
                .PADDR_W(PADDR_W), .PASS_W(OFS_W)) u_rd (
    .clk(clk), .rst_n(rst_n),
    .req_valid(cor_tx_rd_valid), .req_ready(cor_tx_rd_ready),
    .req_vaddr(cor_tx_rd_hdr[VADDR_W+OFS_W-1:OFS_W]), .req_pass(cor_tx_rd_hdr[OFS_W-1:0]),
    .pt_re(pt_re_rd), .virt_addr(afu_virt_rd_addr),
    .phy_addr(afu_phy_rd_addr), .phy_valid(afu_phy_rd_addr_valid),
    .xl_valid(rq_tx_rd_valid), .xl_ready(rq_tx_rd_ready), .xl_paddr(rd_paddr), .xl_pass(rd_pass),
    .fault_evt(rd_evt), .fault_vaddr(rd_fvaddr)
  );

  io_req_chan #(.PT_LATENCY(PT_LATENCY), .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS), .VADDR_W(VADDR_W),
                .PADDR_W(PADDR_W), .PASS_W(WP_W)) u_wr (
    .clk(clk), .rst_n(rst_n),
    .req_valid(cor_tx_wr_valid), .req_ready(cor_tx_wr_ready),
    .req_vaddr(cor_tx_wr_hdr[VADDR_W+OFS_W-1:OFS_W]), .req_pass(wr_pass_in),
    .pt_re(pt_re_wr), .virt_addr(afu_virt_wr_addr),
    .phy_addr(afu_phy_wr_addr), .phy_valid(afu_phy_wr_addr_valid),
    .xl_valid(rq_tx_wr_valid), .xl_ready(rq_tx_wr_ready), .xl_paddr(wr_paddr), .xl_pass(wr_pass),
    .fault_evt(wr_evt), .fault_vaddr(wr_fvaddr)
  );

  assign rq_tx_rd_hdr = {rd_paddr, rd_pass};
  assign rq_tx_wr_hdr = {wr_pass[WP_W-1 -: WR_META_W], wr_paddr, wr_pass[OFS_W-1:0]};
  assign rq_tx_data   = wr_pass[OFS_W +: DATA_W];

  // A fault arriving together with fault_clr is kept, so no event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_fault    <= 1'b0;
      wr_fault    <= 1'b0;
      fault_cnt   <= '0;
      fault_vaddr <= '0;
    end else begin
      rd_fault  <= rd_evt | (rd_fault & ~fault_clr);
      wr_fault  <= wr_evt | (wr_fault & ~fault_clr);
      fault_cnt <= sat_add(fault_clr ? 16'h0 : fault_cnt, {1'b0, rd_evt} + {1'b0, wr_evt});
      if (rd_evt)         fault_vaddr <= rd_fvaddr;
      else if (wr_evt)    fault_vaddr <= wr_fvaddr;
      else if (fault_clr) fault_vaddr <= '0;
    end
  end

`ifdef IO_REQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_cnt   <= '0;
      wr_req_cnt   <= '0;
      rd_stall_cnt <= '0;
      wr_stall_cnt <= '0;
    end else begin
      if (rq_tx_rd_valid & rq_tx_rd_ready)    rd_req_cnt   <= rd_req_cnt + 32'd1;
      if (rq_tx_wr_valid & rq_tx_wr_ready)    wr_req_cnt   <= wr_req_cnt + 32'd1;
      if (cor_tx_rd_valid & ~cor_tx_rd_ready) rd_stall_cnt <= rd_stall_cnt + 32'd1;
      if (cor_tx_wr_valid & ~cor_tx_wr_ready) wr_stall_cnt <= wr_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_io_requester_pt.sv
// Directed bench for io_requester_pt: vector table for single transactions plus hand-written
// sequences for backpressure, fault saturation and mid-burst reset.

module tb_io_requester_pt;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cor_tx_rd_ready, cor_tx_rd_valid;
  logic [70:0]  cor_tx_rd_hdr;
  logic         cor_tx_wr_ready, cor_tx_wr_valid;
  logic [74:0]  cor_tx_wr_hdr;
  logic [511:0] cor_tx_data;
  logic         rq_tx_rd_ready, rq_tx_rd_valid;
  logic [44:0]  rq_tx_rd_hdr;
  logic         rq_tx_wr_ready, rq_tx_wr_valid;
  logic [48:0]  rq_tx_wr_hdr;
  logic [511:0] rq_tx_data;
  logic         pt_re_rd, pt_re_wr;
  logic [57:0]  afu_virt_rd_addr, afu_virt_wr_addr;
  logic [31:0]  afu_phy_rd_addr, afu_phy_wr_addr;
  logic         afu_phy_rd_addr_valid, afu_phy_wr_addr_valid;
  logic         fault_clr, rd_fault, wr_fault;
  logic [57:0]  fault_vaddr;
  logic [15:0]  fault_cnt;
`ifdef IO_REQ_PERF_CNT_EN
  logic [31:0]  rd_req_cnt, wr_req_cnt, rd_stall_cnt, wr_stall_cnt;
`endif

  io_requester_pt dut (
    .clk(clk), .rst_n(rst_n),
    .cor_tx_rd_ready(cor_tx_rd_ready), .cor_tx_rd_valid(cor_tx_rd_valid), .cor_tx_rd_hdr(cor_tx_rd_hdr),
    .cor_tx_wr_ready(cor_tx_wr_ready), .cor_tx_wr_valid(cor_tx_wr_valid), .cor_tx_wr_hdr(cor_tx_wr_hdr),
    .cor_tx_data(cor_tx_data),
    .rq_tx_rd_ready(rq_tx_rd_ready), .rq_tx_rd_valid(rq_tx_rd_valid), .rq_tx_rd_hdr(rq_tx_rd_hdr),
    .rq_tx_wr_ready(rq_tx_wr_ready), .rq_tx_wr_valid(rq_tx_wr_valid), .rq_tx_wr_hdr(rq_tx_wr_hdr),
    .rq_tx_data(rq_tx_data),
    .pt_re_rd(pt_re_rd), .pt_re_wr(pt_re_wr),
    .afu_virt_rd_addr(afu_virt_rd_addr), .afu_virt_wr_addr(afu_virt_wr_addr),
    .afu_phy_rd_addr(afu_phy_rd_addr), .afu_phy_wr_addr(afu_phy_wr_addr),
    .afu_phy_rd_addr_valid(afu_phy_rd_addr_valid), .afu_phy_wr_addr_valid(afu_phy_wr_addr_valid),
    .fault_clr(fault_clr), .rd_fault(rd_fault), .wr_fault(wr_fault),
    .fault_vaddr(fault_vaddr), .fault_cnt(fault_cnt)
`ifdef IO_REQ_PERF_CNT_EN
    , .rd_req_cnt(rd_req_cnt), .wr_req_cnt(wr_req_cnt),
    .rd_stall_cnt(rd_stall_cnt), .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pagetable model: result presented two cycles after the strobe, sampled by the DUT on the third edge.
  logic [57:0] rd_p1, rd_p2, wr_p1, wr_p2;
  logic        rd_hit, wr_hit;
  always @(posedge clk) begin
    rd_p1 <= afu_virt_rd_addr; rd_p2 <= rd_p1;
    wr_p1 <= afu_virt_wr_addr; wr_p2 <= wr_p1;
  end
  assign afu_phy_rd_addr       = rd_p2[31:0] ^ 32'h0000_1123;
  assign afu_phy_wr_addr       = wr_p2[31:0] ^ 32'h0000_1123;
  assign afu_phy_rd_addr_valid = rd_hit;
  assign afu_phy_wr_addr_valid = wr_hit;

  // Output monitor
  int          rd_vcnt = 0, wr_vcnt = 0;
  logic [44:0] rd_log [$];
  always @(posedge clk) begin
    if (rq_tx_rd_valid) rd_vcnt <= rd_vcnt + 1;
    if (rq_tx_wr_valid) wr_vcnt <= wr_vcnt + 1;
    if (rq_tx_rd_valid && rq_tx_rd_ready) rd_log.push_back(rq_tx_rd_hdr);
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
  endtask

  typedef struct {
    logic         is_wr;
    logic         hit;
    logic [57:0]  vaddr;
    logic [12:0]  meta;
    logic [3:0]   wmeta;
    logic [511:0] data;
    logic [48:0]  exp_hdr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int base;
    if (v.is_wr) wr_hit = v.hit; else rd_hit = v.hit;
    @(negedge clk);
    base = v.is_wr ? wr_vcnt : rd_vcnt;
    if (v.is_wr) begin
      cor_tx_wr_valid = 1'b1; cor_tx_wr_hdr = {v.wmeta, v.vaddr, v.meta}; cor_tx_data = v.data;
      chk("wr_ready_idle", cor_tx_wr_ready, 1);
    end else begin
      cor_tx_rd_valid = 1'b1; cor_tx_rd_hdr = {v.vaddr, v.meta};
      chk("rd_ready_idle", cor_tx_rd_ready, 1);
    end
    @(negedge clk);
    cor_tx_rd_valid = 1'b0; cor_tx_wr_valid = 1'b0;
    chk("pt_re", v.is_wr ? pt_re_wr : pt_re_rd, 1);
    chk("virt_addr", v.is_wr ? afu_virt_wr_addr : afu_virt_rd_addr, v.vaddr);
    if (v.hit) begin
      repeat (4) @(negedge clk);
      chk("latency_early", v.is_wr ? rq_tx_wr_valid : rq_tx_rd_valid, 0);
      @(negedge clk);
      chk("latency_valid", v.is_wr ? rq_tx_wr_valid : rq_tx_rd_valid, 1);
      chk("out_hdr", v.is_wr ? rq_tx_wr_hdr : {4'h0, rq_tx_rd_hdr}, v.exp_hdr);
      if (v.is_wr) chk("out_data", rq_tx_data, v.data);
      @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
      chk("dropped", (v.is_wr ? wr_vcnt : rd_vcnt) - base, 0);
      chk("fault_flag", v.is_wr ? wr_fault : rd_fault, 1);
      chk("fault_vaddr", fault_vaddr, v.vaddr);
      chk("fault_cnt", fault_cnt, 1);
      pulse_clr();
      chk("clr_flag", {rd_fault, wr_fault}, 0);
      chk("clr_cnt", fault_cnt, 0);
      chk("clr_vaddr", fault_vaddr, 0);
    end
    rd_hit = 1'b1; wr_hit = 1'b1;
  endtask

  task automatic burst(input int n, input logic clr_end);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      cor_tx_rd_valid = 1'b1; cor_tx_wr_valid = 1'b1;
      cor_tx_rd_hdr = {58'(i), 13'h0};
      cor_tx_wr_hdr = {4'h0, 58'(i) | 58'h100_0000_0000, 13'h0};
      @(negedge clk);
    end
    cor_tx_rd_valid = 1'b0; cor_tx_wr_valid = 1'b0; fault_clr = clr_end;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t vecs [7];

  initial begin
    int n, stalls, base, waited;
`ifdef IO_REQ_PERF_CNT_EN
    logic [31:0] req0, st0;
`endif
    vecs[0] = '{1'b0, 1'b1, 58'h1000, 13'h0A5, 4'h0, '0, {4'h0, 32'h0000_0123, 13'h0A5}};
    vecs[1] = '{1'b0, 1'b1, 58'h3FF_FFFF_FFFF_FFFF, 13'h1FFF, 4'h0, '0, {4'h0, 32'hFFFF_EEDC, 13'h1FFF}};
    vecs[2] = '{1'b0, 1'b1, 58'h2_0000_1123, 13'h1555, 4'h0, '0, {4'h0, 32'h0000_0000, 13'h1555}};
    vecs[3] = '{1'b1, 1'b1, 58'h00AB_CDEF, 13'h0F0, 4'hA, {16{32'hDEAD_BEEF}}, {4'hA, 32'h00AB_DCCC, 13'h0F0}};
    vecs[4] = '{1'b1, 1'b1, 58'h3FF_FFFF_0000_0000, 13'h1FFF, 4'hF, {512{1'b1}}, {4'hF, 32'h0000_1123, 13'h1FFF}};
    vecs[5] = '{1'b0, 1'b0, 58'h0BAD, 13'h001, 4'h0, '0, '0};
    vecs[6] = '{1'b1, 1'b0, 58'h1_2345_6789, 13'h002, 4'h3, '0, '0};

    rst_n = 1'b0; fault_clr = 1'b0; rd_hit = 1'b1; wr_hit = 1'b1;
    cor_tx_rd_valid = 1'b0; cor_tx_wr_valid = 1'b0; cor_tx_rd_hdr = '0; cor_tx_wr_hdr = '0; cor_tx_data = '0;
    rq_tx_rd_ready = 1'b1; rq_tx_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {cor_tx_rd_ready, cor_tx_wr_ready}, 0);
    chk("rst_valid", {rq_tx_rd_valid, rq_tx_wr_valid, pt_re_rd, pt_re_wr}, 0);
    chk("rst_fault", {rd_fault, wr_fault, fault_cnt, fault_vaddr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure: D+1 requests fit while the consumer is stalled.
    rq_tx_rd_ready = 1'b0; n = 0; stalls = 0; base = rd_log.size();
`ifdef IO_REQ_PERF_CNT_EN
    req0 = rd_req_cnt; st0 = rd_stall_cnt;
`endif
    @(negedge clk);
    for (int cyc = 0; cyc < 60; cyc++) begin
      cor_tx_rd_valid = (n < 40);
      cor_tx_rd_hdr   = {58'(n + 100), 13'(n)};
      if (cor_tx_rd_valid && cor_tx_rd_ready) n++;
      else if (cor_tx_rd_valid) stalls++;
      @(negedge clk);
    end
    cor_tx_rd_valid = 1'b0;
    chk("bp_accepted", n, 33);
    chk("bp_ready_low", cor_tx_rd_ready, 0);
    chk("bp_no_xfer", rd_log.size() - base, 0);
    rq_tx_rd_ready = 1'b1;
    waited = 0;
    while (rd_log.size() - base < 33 && waited < 200) begin
      @(negedge clk); waited++;
    end
    repeat (10) @(negedge clk);
    chk("bp_drain_cnt", rd_log.size() - base, 33);
    for (int i = 0; i < 33 && base + i < rd_log.size(); i++)
      chk("bp_order", rd_log[base + i], {32'(i + 100) ^ 32'h0000_1123, 13'(i)});
`ifdef IO_REQ_PERF_CNT_EN
    chk("perf_rd_req", rd_req_cnt - req0, 33);
    chk("perf_rd_stall", rd_stall_cnt - st0, 32'(stalls));
`endif

    // Simultaneous RD and WR faults, then saturation and clear-vs-event priority.
    rd_hit = 1'b0; wr_hit = 1'b0;
    @(negedge clk);
    cor_tx_rd_valid = 1'b1; cor_tx_rd_hdr = {58'h111, 13'h0};
    cor_tx_wr_valid = 1'b1; cor_tx_wr_hdr = {4'h0, 58'h222, 13'h0};
    @(negedge clk);
    cor_tx_rd_valid = 1'b0; cor_tx_wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pair_flags", {rd_fault, wr_fault}, 2'b11);
    chk("pair_cnt", fault_cnt, 2);
    chk("pair_vaddr", fault_vaddr, 58'h111);
    burst(32800, 1'b0);
    chk("sat_cnt", fault_cnt, 16'hFFFF);
    burst(5, 1'b1);
    chk("clr_vs_evt_cnt", fault_cnt, 6);
    chk("clr_vs_evt_vaddr", fault_vaddr, 58'd4);
    chk("clr_vs_evt_flags", {rd_fault, wr_fault}, 2'b11);
    rd_hit = 1'b1; wr_hit = 1'b1;
    pulse_clr();
    chk("final_clr", {rd_fault, wr_fault, fault_cnt}, 0);

    // Reset in the middle of a request burst.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        chk("pre_rst_pt_re", pt_re_rd, 1);
        cor_tx_rd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", cor_tx_rd_ready, 0);
        chk("mid_rst_outs", {pt_re_rd, rq_tx_rd_valid, rq_tx_rd_hdr, afu_virt_rd_addr}, 0);
        break;
      end
      cor_tx_rd_valid = 1'b1; cor_tx_rd_hdr = {58'(i + 500), 13'(i)};
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = rd_vcnt;
    repeat (10) @(negedge clk);
    chk("no_stale_valid", rd_vcnt - base, 0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
